// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel collector.
package deser_pkg;

   typedef enum logic {FILL, FULL} deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Packs N consecutive WIDTH-bit beats into one N*WIDTH-bit word.
// Valid/ready handshakes are used on both the narrow and wide sides.
module deserializer
   import deser_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N*WIDTH-1:0]        out,
   output logic [$clog2(N+1)-1:0]    count
);

   localparam int unsigned CW = $clog2(N + 1);

   if (N < 2) begin : g_bad_n
      $error("deserializer: N must be at least 2");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("deserializer: WIDTH must be at least 1");
   end

   deser_state_t   state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  idx;
   logic           accept;
   logic           retire;
   logic [N-1:0]   lane_we;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               count_d = count_q + CW'(1);
               if (count_q == CW'(N - 1)) begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            if (retire) begin
               state_d = FILL;
               count_d = accept ? CW'(1) : '0;
            end
         end
         default: begin
            state_d = FILL;
            count_d = '0;
         end
      endcase
   end

   // Outputs; in_ready deliberately has no path from in_valid.
   always_comb begin
      out_valid = (state_q == FULL);
      in_ready  = !reset && (!out_valid || out_ready);
      accept    = in_valid && in_ready;
      retire    = out_valid && out_ready;
      // In FULL a beat can only arrive alongside a retire, so it opens the next word.
      idx       = (state_q == FULL) ? '0 : count_q;
      count     = count_q;
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      logic [WIDTH-1:0] lane_q;

      assign lane_we[k] = accept && (idx == CW'(k));

      always_ff @(posedge clk) begin
         if (reset) begin
            lane_q <= '0;
         end else if (lane_we[k]) begin
            lane_q <= in;
         end
      end

      assign out[k*WIDTH +: WIDTH] = lane_q;
   end

endmodule

// File: tb/tb_deserializer.sv
// Randomised and directed stimulus against a queue-based model of the collector.
module tb_deserializer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 4;
   localparam int unsigned CW    = $clog2(N + 1);

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic [WIDTH-1:0]     din;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*WIDTH-1:0]   out;
   logic [CW-1:0]        count;

   int checks = 0;
   int errors = 0;

   deserializer #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in        (din),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: beats gathered so far, whether a finished word awaits retirement,
   // and the words still owed to the consumer.
   logic [WIDTH-1:0]   m_beats[$];
   bit                 m_full = 1'b0;
   logic [N*WIDTH-1:0] exp_q[$];

   always @(posedge clk) begin
      logic [N*WIDTH-1:0] word;
      bit                 rdy;
      if (reset) begin
         m_beats.delete();
         exp_q.delete();
         m_full = 1'b0;
      end else begin
         rdy = !m_full || out_ready;
         if (m_full && out_ready) m_full = 1'b0;
         if (in_valid && rdy) begin
            m_beats.push_back(din);
            if (m_beats.size() == N) begin
               word = '0;
               for (int k = 0; k < int'(N); k++) word[k*WIDTH +: WIDTH] = m_beats[k];
               exp_q.push_back(word);
               m_beats.delete();
               m_full = 1'b1;
            end
         end
      end
   end

   // Monitor on the falling edge, away from the active edge.
   bit                 prev_stall = 1'b0;
   logic [N*WIDTH-1:0] prev_out;

   always @(negedge clk) begin
      logic [N*WIDTH-1:0] exp_word;
      check("out_valid", longint'(out_valid), longint'(m_full));
      check("count", longint'(count), m_full ? longint'(N) : longint'(m_beats.size()));
      check("in_ready", longint'(in_ready), longint'(!reset && (!m_full || out_ready)));
      if (prev_stall && out_valid) check("out_stable", longint'(out), longint'(prev_out));
      if (out_valid && out_ready && !reset) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", longint'(out), 0);
            errors += (out == 0) ? 1 : 0;
         end else begin
            exp_word = exp_q.pop_front();
            check("word", longint'(out), longint'(exp_word));
         end
      end
      prev_stall = out_valid && !out_ready && !reset;
      prev_out   = out;
   end

   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r);
      in_valid  = v;
      din       = d;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] gap_d[7];
      bit               gap_v[7];
      reset     = 1'b1;
      in_valid  = 1'b0;
      din       = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("reset_out", longint'(out), 0);
      check("reset_in_ready", longint'(in_ready), 0);
      reset = 1'b0;
      #1;
      check("post_reset_in_ready", longint'(in_ready), 1);

      // Basic pack.
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 'h11), 1'b1);
      check("basic_valid", longint'(out_valid), 1);
      check("basic_out", longint'(out), 64'h44332211);
      cyc(1'b0, 8'h00, 1'b1);

      // Back-pressure then release with a beat waiting.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hFF, 1'b0);
      check("bp_out", longint'(out), 64'hA3A2A1A0);
      check("bp_count", longint'(count), 4);
      cyc(1'b1, 8'hFF, 1'b1);
      check("bp_release_count", longint'(count), 1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
      reset = 1'b1;
      cyc(1'b0, 8'h00, 1'b1);
      reset = 1'b0;

      // Back-to-back streaming.
      for (int i = 0; i < 12; i++) cyc(1'b1, 8'(i), 1'b1);
      cyc(1'b0, 8'h00, 1'b1);

      // Gapped input.
      gap_d = '{8'h5A, 8'h00, 8'h5B, 8'h00, 8'h00, 8'h5C, 8'h5D};
      gap_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) cyc(gap_v[i], gap_d[i], 1'b0);
      check("gap_out", longint'(out), 64'h5D5C5B5A);
      cyc(1'b0, 8'h00, 1'b1);

      // Reset mid-word; the beat offered during reset must be dropped.
      cyc(1'b1, 8'h01, 1'b1);
      cyc(1'b1, 8'h02, 1'b1);
      reset = 1'b1;
      cyc(1'b1, 8'h77, 1'b1);
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i * 'h10), 1'b0);
      check("reset_mid_out", longint'(out), 64'h40302010);
      cyc(1'b0, 8'h00, 1'b1);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(63) == 0);
         cyc(($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 6));
      end
      reset = 1'b0;

      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
      check("drained", longint'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
